// File: rtl/cla_32bit_adder_if.sv
// Operand and result bundle for the 32-bit carry-lookahead adder.
// The master drives operands and carry-in; the slave returns the registered results.
interface cla_32bit_adder_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic [31:0] S;
    logic        C_out;
    logic        G_prime;
    logic        P_prime;

    modport master (
        output A,
        output B,
        output Cin,
        input  S,
        input  C_out,
        input  G_prime,
        input  P_prime
    );

    modport slave (
        input  A,
        input  B,
        input  Cin,
        output S,
        output C_out,
        output G_prime,
        output P_prime
    );
endinterface

// File: rtl/cla_32bit_adder.sv
// Registered 32-bit two-level carry-lookahead adder: 4-bit groups, two 16-bit sections,
// and a top-level lookahead. It also exposes the whole-word group generate/propagate terms.
module cla_32bit_adder (
    input logic              clk,
    input logic              clr,
    cla_32bit_adder_if.slave bus
);

    // Carries into positions 0..3 of a 4-wide lookahead block, from its own carry-in.
    function automatic logic [3:0] carries4(input logic [3:0] p, input logic [3:0] g,
                                            input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    function automatic logic group_gen(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [31:0] p;
    logic [31:0] g;
    logic [31:0] c;
    logic [7:0]  pg;
    logic [7:0]  gg;
    logic [7:0]  gc;
    logic        p16_lo;
    logic        g16_lo;
    logic        p16_hi;
    logic        g16_hi;
    logic        c16;

    logic [31:0] s_d;
    logic [31:0] s_q;
    logic        c_out_d;
    logic        c_out_q;
    logic        g_prime_d;
    logic        g_prime_q;
    logic        p_prime_d;
    logic        p_prime_q;

    always_comb begin
        p = bus.A ^ bus.B;
        g = bus.A & bus.B;

        for (int k = 0; k < 8; k++) begin
            pg[k] = &p[4*k +: 4];
            gg[k] = group_gen(p[4*k +: 4], g[4*k +: 4]);
        end

        p16_lo = &pg[3:0];
        g16_lo = group_gen(pg[3:0], gg[3:0]);
        p16_hi = &pg[7:4];
        g16_hi = group_gen(pg[7:4], gg[7:4]);

        // Section carry comes from the top-level lookahead, never from the low section's groups.
        c16 = g16_lo | (p16_lo & bus.Cin);

        gc[3:0] = carries4(pg[3:0], gg[3:0], bus.Cin);
        gc[7:4] = carries4(pg[7:4], gg[7:4], c16);

        for (int k = 0; k < 8; k++) begin
            c[4*k +: 4] = carries4(p[4*k +: 4], g[4*k +: 4], gc[k]);
        end

        s_d       = p ^ c;
        p_prime_d = p16_hi & p16_lo;
        g_prime_d = g16_hi | (p16_hi & g16_lo);
        c_out_d   = g_prime_d | (p_prime_d & bus.Cin);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            s_q       <= '0;
            c_out_q   <= 1'b0;
            g_prime_q <= 1'b0;
            p_prime_q <= 1'b0;
        end else begin
            s_q       <= s_d;
            c_out_q   <= c_out_d;
            g_prime_q <= g_prime_d;
            p_prime_q <= p_prime_d;
        end
    end

    assign bus.S       = s_q;
    assign bus.C_out   = c_out_q;
    assign bus.G_prime = g_prime_q;
    assign bus.P_prime = p_prime_q;

endmodule

// File: tb/tb_cla_32bit_adder.sv
// Bench for cla_32bit_adder: literal directed vectors plus a random stream checked every
// cycle against a plain 33-bit arithmetic model.
module tb_cla_32bit_adder;

    logic clk;
    logic clr;
    int   n_cmp;
    int   n_err;

    cla_32bit_adder_if bus ();

    cla_32bit_adder dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sample inputs at every rising edge, check the registered outputs just after.
    initial begin
        logic [32:0] full;
        logic [32:0] no_cin;
        logic [31:0] e_s;
        logic        e_c;
        logic        e_g;
        logic        e_p;
        forever begin
            @(posedge clk);
            full   = {1'b0, bus.A} + {1'b0, bus.B} + {32'd0, bus.Cin};
            no_cin = {1'b0, bus.A} + {1'b0, bus.B};
            if (clr === 1'b0) begin
                e_s = '0;
                e_c = 1'b0;
                e_g = 1'b0;
                e_p = 1'b0;
            end else begin
                e_s = full[31:0];
                e_c = full[32];
                e_g = no_cin[32];
                e_p = ((bus.A ^ bus.B) == 32'hFFFF_FFFF);
            end
            #1;
            check("model_S", bus.S, e_s);
            check("model_C_out", {31'd0, bus.C_out}, {31'd0, e_c});
            check("model_G_prime", {31'd0, bus.G_prime}, {31'd0, e_g});
            check("model_P_prime", {31'd0, bus.P_prime}, {31'd0, e_p});
        end
    end

    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic rst_n);
        @(negedge clk);
        bus.A   = a;
        bus.B   = b;
        bus.Cin = cin;
        clr     = rst_n;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_all(input string name, input logic [31:0] s, input logic c,
                              input logic gp, input logic pp);
        check({name, "_S"}, bus.S, s);
        check({name, "_C_out"}, {31'd0, bus.C_out}, {31'd0, c});
        check({name, "_G_prime"}, {31'd0, bus.G_prime}, {31'd0, gp});
        check({name, "_P_prime"}, {31'd0, bus.P_prime}, {31'd0, pp});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_cmp   = 0;
        n_err   = 0;
        clr     = 1'b0;
        bus.A   = 32'hFFFF_FFFF;
        bus.B   = 32'h0000_0001;
        bus.Cin = 1'b0;

        step(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        expect_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        expect_all("release_chain", 32'h0, 1'b1, 1'b1, 1'b0);

        step(32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 1'b1);
        expect_all("propagate_cin0", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        step(32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 1'b1);
        expect_all("propagate_cin1", 32'h0, 1'b1, 1'b0, 1'b1);

        step(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        expect_all("msb_generate", 32'h0000_0001, 1'b1, 1'b1, 1'b0);

        // Three operations on consecutive edges.
        step(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
        expect_all("pipe0", 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        expect_all("pipe1", 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        step(32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1);
        expect_all("pipe2", 32'h1234_5679, 1'b0, 1'b0, 1'b0);

        // A clr pulse between edges must not reset anything.
        @(negedge clk);
        bus.A   = 32'h0000_FFFF;
        bus.B   = 32'h0000_0001;
        bus.Cin = 1'b0;
        #1 clr = 1'b0;
        #2 clr = 1'b1;
        @(posedge clk);
        #2;
        expect_all("clr_glitch", 32'h0001_0000, 1'b0, 1'b0, 1'b0);

        // Mid-stream reset discards that cycle, next edge loads normally.
        step(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0);
        expect_all("mid_reset", 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b1);
        expect_all("after_reset", 32'hEFBE_D001, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = ~ra;
                1: rb = ~ra ^ (32'h1 << $urandom_range(0, 31));
                2: rb = 32'h1;
                default: ;
            endcase
            @(negedge clk);
            bus.A   = ra;
            bus.B   = rb;
            bus.Cin = 1'($urandom_range(0, 1));
            clr     = ($urandom_range(0, 63) != 0);
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #3;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cla_32bit_adder.md
# cla_32bit_adder

Registered 32-bit two-level carry-lookahead adder that computes A + B + Cin and exposes the carry-out and the whole-word group generate/propagate terms. It is the adder core of the ALU datapath, used for ADD/SUB and for address and increment arithmetic. The lookahead group signals let a wider or cascaded adder chain this block without ripple. Outputs are captured in a register stage on the system clock.

## Interface

Parameters: none. Width is fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- clr  input  1  reset; synchronous, active-low (0 = reset)
- A  input  32  operand A, unsigned/two's-complement agnostic
- B  input  32  operand B
- Cin  input  1  carry into bit 0
- S  output  32  registered sum bits, (A + B + Cin) mod 2^32
- C_out  output  1  registered carry out of bit 31
- G_prime  output  1  registered 32-bit group generate, independent of Cin
- P_prime  output  1  registered 32-bit group propagate, independent of Cin

## Operation

- Bit level: p[i] = A[i] XOR B[i], g[i] = A[i] AND B[i], S[i] = p[i] XOR c[i], c[0] = Cin.
- Level 1: eight 4-bit CLA groups.
  - Each group forms its internal carries by full lookahead from its own carry-in.
  - Each group outputs group terms PG = p3&p2&p1&p0 and GG = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- Level 2: two 4-group lookahead units, covering bits 0–15 and bits 16–31.
  - Each unit produces the group carry-ins from its four (PG, GG) pairs and emits section terms P16 and G16.
- Top: carry into bit 16 = G16_lo | P16_lo & Cin.
  - P_prime = P16_hi & P16_lo.
  - G_prime = G16_hi | P16_hi & G16_lo.
  - C_out = G_prime | P_prime & Cin.
- Carries between groups come only from the lookahead equations. Group-to-group ripple is not permitted.
- P_prime = 1 exactly when A XOR B = FFFFFFFF. G_prime = 1 exactly when A + B ≥ 2^32 with Cin = 0.
- There is no overflow flag and no signed interpretation; callers derive overflow externally.

## Timing

- Datapath is combinational from A/B/Cin to the output register D-inputs.
- On each rising clk:
  - If clr = 0: S ← 0, C_out ← 0, G_prime ← 0, P_prime ← 0.
  - Otherwise all four outputs load the combinational results.
- Latency is 1 cycle. Results for inputs present before edge N are visible after edge N. A new operation may be issued every cycle; there is no handshake and no stall.
- Reset value of every output is 0. Reset is synchronous only, so asserting clr between edges has no effect until the next edge.
- Reset mid-stream: the edge with clr = 0 discards that cycle's result. The first edge after clr returns to 1 registers the inputs present at that edge.
- Outputs are undefined before the first clk edge and must be reset before use.
- Inputs must be stable for setup before the edge. The critical path is bit-level p/g → level 1 → level 2 → top → level 2 → level 1 → S[31], and it must meet the system clock.

## Test plan

- Reset: clr = 0 for 2 edges with A = FFFFFFFF, B = 1 -> S = 00000000, C_out = 0, G_prime = 0, P_prime = 0. Release clr -> next edge S = 00000000, C_out = 1.
- Full propagate: A = 55555555, B = AAAAAAAA, Cin = 0 -> after 1 edge S = FFFFFFFF, C_out = 0, P_prime = 1, G_prime = 0. Same operands with Cin = 1 -> S = 00000000, C_out = 1, P_prime = 1.
- Full carry chain: A = FFFFFFFF, B = 00000001, Cin = 0 -> S = 00000000, C_out = 1, G_prime = 1, P_prime = 0.
- MSB generate with carry-in: A = 80000000, B = 80000000, Cin = 1 -> S = 00000001, C_out = 1, G_prime = 1, P_prime = 0.
- Back-to-back pipelining: apply three operations on consecutive edges -> each result appears exactly one edge after its inputs, with no bubbles.
- Random regression: ≥10,000 random (A, B, Cin) vectors checked against a behavioural 33-bit sum {C_out, S}, plus P_prime = &(A^B) and G_prime = carry-out of A + B.
